// File: rtl/oam_dma_pkg.sv
// Shared PPU-side definitions for the sprite DMA engine.
//   state_e    : DMA sequencer states
//   OAMDMA_REG : CPU address of the OAMDMA trigger register
//   XFER_LEN   : bytes copied per transfer (one CPU page)
package oam_dma_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } state_e;

    localparam logic [15:0] OAMDMA_REG = 16'h4014;
    localparam int unsigned XFER_LEN   = 256;

endpackage

// File: rtl/oam_dma_if.sv
// CPU bus / OAM write-port bundle seen by the sprite DMA engine.
//   master : the DMA side (samples CPU writes and read data, drives halt/read/OAM-write)
//   slave  : the system side (CPU fabric, bus memory and OAM)
// Signals:
//   cpu_addr/cpu_we/cpu_wdata : CPU write snoop for the trigger register
//   cpu_halted                : CPU has stopped and released the bus
//   oam_start                 : current OAMADDR
//   halt_req/dma_active       : halt request / bus ownership
//   mem_addr/mem_rd/mem_rdata : bus read port
//   oam_addr/oam_we/oam_wdata : OAM write port
interface oam_dma_if #(
    parameter int unsigned OAM_AW = 8
) ();

    logic [15:0]       cpu_addr;
    logic              cpu_we;
    logic [7:0]        cpu_wdata;
    logic              cpu_halted;
    logic [OAM_AW-1:0] oam_start;
    logic              halt_req;
    logic              dma_active;
    logic [15:0]       mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic [OAM_AW-1:0] oam_addr;
    logic              oam_we;
    logic [7:0]        oam_wdata;

    modport master (
        input  cpu_addr, cpu_we, cpu_wdata, cpu_halted, oam_start, mem_rdata,
        output halt_req, dma_active, mem_addr, mem_rd, oam_addr, oam_we, oam_wdata
    );

    modport slave (
        output cpu_addr, cpu_we, cpu_wdata, cpu_halted, oam_start, mem_rdata,
        input  halt_req, dma_active, mem_addr, mem_rd, oam_addr, oam_we, oam_wdata
    );

endinterface

// File: rtl/oam_dma.sv
// Sprite DMA master. A CPU write to $4014 latches a page number and OAMADDR, requests a
// CPU halt, then copies XFER_LEN bytes from $XX00.. into OAM starting at OAMADDR, one
// READ/WRITE pair per byte. Reads always land on get cycles; an ALIGN cycle is inserted
// when the halt is granted on the wrong parity.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clk_en  : CPU-cycle enable; state only advances when high
//   dma_io  : CPU snoop, bus read port and OAM write port (master side)
module oam_dma #(
    parameter int unsigned OAM_AW   = 8,
    parameter int unsigned XFER_LEN = oam_dma_pkg::XFER_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    oam_dma_if.master  dma_io
);

    import oam_dma_pkg::*;

    localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

    state_e            state_q;
    logic              put_q;
    logic [7:0]        page_q;
    logic [7:0]        idx_q;
    logic [OAM_AW-1:0] base_q;
    logic              halt_req_q;
    logic              dma_active_q;
    logic              mem_rd_q;
    logic [15:0]       mem_addr_q;
    logic              oam_we_q;
    logic [OAM_AW-1:0] oam_addr_q;
    logic [7:0]        oam_wdata_q;  // doubles as the byte data register

    logic trigger;
    assign trigger = dma_io.cpu_we && (dma_io.cpu_addr == OAMDMA_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            put_q        <= 1'b0;
            page_q       <= '0;
            idx_q        <= '0;
            base_q       <= '0;
            halt_req_q   <= 1'b0;
            dma_active_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            oam_we_q     <= 1'b0;
            oam_addr_q   <= '0;
            oam_wdata_q  <= '0;
        end else if (clk_en) begin
            put_q    <= ~put_q;
            mem_rd_q <= 1'b0;
            oam_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        page_q     <= dma_io.cpu_wdata;
                        base_q     <= dma_io.oam_start;
                        idx_q      <= '0;
                        halt_req_q <= 1'b1;
                        state_q    <= StHalt;
                    end
                end
                StHalt: begin
                    if (dma_io.cpu_halted) begin
                        dma_active_q <= 1'b1;
                        // put_q high now means the next cycle is a get cycle
                        if (put_q) begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= {page_q, idx_q};
                            state_q    <= StRead;
                        end else begin
                            state_q <= StAlign;
                        end
                    end
                end
                StAlign: begin
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {page_q, idx_q};
                    state_q    <= StRead;
                end
                StRead: begin
                    oam_wdata_q <= dma_io.mem_rdata;
                    oam_addr_q  <= base_q + OAM_AW'(idx_q);
                    oam_we_q    <= 1'b1;
                    state_q     <= StWrite;
                end
                StWrite: begin
                    if (idx_q == LastIdx) begin
                        halt_req_q   <= 1'b0;
                        dma_active_q <= 1'b0;
                        state_q      <= StIdle;
                    end else begin
                        idx_q      <= idx_q + 8'd1;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {page_q, idx_q + 8'd1};
                        state_q    <= StRead;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dma_io.halt_req   = halt_req_q;
    assign dma_io.dma_active = dma_active_q;
    assign dma_io.mem_rd     = mem_rd_q;
    assign dma_io.mem_addr   = mem_addr_q;
    // Qualified by clk_en so a stalled WRITE cycle never issues a second OAM write.
    assign dma_io.oam_we     = oam_we_q & clk_en;
    assign dma_io.oam_addr   = oam_addr_q;
    assign dma_io.oam_wdata  = oam_wdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: expected bus reads and OAM writes are queued when a
// transfer is launched and popped as the DUT issues them.
module tb_oam_dma;

    localparam int XferLen = 256;

    logic clk;
    logic rst_n;
    logic clk_en;
    bit   put;          // model of the DUT get/put parity for the current cycle

    int checks = 0;
    int errors = 0;
    int rd_seen, wr_seen, align_seen, last_n;

    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];  // {oam_addr, oam_wdata}
    logic [7:0]  oam_model [XferLen];

    oam_dma_if #(.OAM_AW(8)) dif ();

    oam_dma #(
        .OAM_AW   (8),
        .XFER_LEN (XferLen)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .dma_io (dif.master)
    );

    function automatic logic [7:0] memval(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] * 8'd29) ^ 8'h5A;
    endfunction

    assign dif.mem_rdata = memval(dif.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (clk_en && dif.mem_rd) begin
            rd_seen++;
            if (exp_rd.size() == 0) chk("read unexpected", 32'(dif.mem_rd), 32'd0);
            else chk("read addr", 32'(dif.mem_addr), 32'(exp_rd.pop_front()));
        end
        if (dif.oam_we) begin
            wr_seen++;
            chk("oam_we with clk_en low", 32'(clk_en), 32'd1);
            if (exp_wr.size() == 0) chk("write unexpected", 32'(dif.oam_we), 32'd0);
            else chk("write addr/data", 32'({dif.oam_addr, dif.oam_wdata}),
                     32'(exp_wr.pop_front()));
            oam_model[dif.oam_addr] = dif.oam_wdata;
        end
        if (clk_en && dif.dma_active && !dif.mem_rd && !dif.oam_we) align_seen++;
    end

    task automatic step(input bit en);
        clk_en = en;
        @(posedge clk);
        #1;
        if (en) put = ~put;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        clk_en         = 1'b0;
        dif.cpu_we     = 1'b0;
        dif.cpu_addr   = 16'h0000;
        dif.cpu_wdata  = 8'h00;
        dif.cpu_halted = 1'b0;
        dif.oam_start  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        put   = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " halt_req"}, 32'(dif.halt_req), 32'd0);
        chk({tag, " dma_active"}, 32'(dif.dma_active), 32'd0);
        chk({tag, " mem_rd"}, 32'(dif.mem_rd), 32'd0);
        chk({tag, " mem_addr"}, 32'(dif.mem_addr), 32'd0);
        chk({tag, " oam_we"}, 32'(dif.oam_we), 32'd0);
        chk({tag, " oam_addr"}, 32'(dif.oam_addr), 32'd0);
        chk({tag, " oam_wdata"}, 32'(dif.oam_wdata), 32'd0);
    endtask

    // want_p: required parity of the trigger cycle (-1 = any).
    task automatic run_xfer(input logic [7:0] page, input logic [7:0] start, input int want_p,
                            input int delay, input bit gaps, input bit retrig, input bit abort,
                            input string tag);
        int n, exp_n, guard, bad, wr_snap;
        bit align, en;
        if (want_p >= 0 && put != want_p[0]) step(1'b1);
        rd_seen = 0;
        wr_seen = 0;
        align_seen = 0;
        for (int i = 0; i < XferLen; i++) begin
            exp_rd.push_back({page, 8'(i)});
            exp_wr.push_back({8'(start + 8'(i)), memval({page, 8'(i)})});
        end
        dif.cpu_halted = (delay == 0);
        dif.cpu_addr   = 16'h4014;
        dif.cpu_wdata  = page;
        dif.oam_start  = start;
        dif.cpu_we     = 1'b1;
        step(1'b1);
        dif.cpu_we    = 1'b0;
        dif.oam_start = start ^ 8'h33;
        chk({tag, " halt_req rise"}, 32'(dif.halt_req), 32'd1);
        chk({tag, " not active in HALT"}, 32'(dif.dma_active), 32'd0);
        n = 0;
        guard = 0;
        while (n < delay && guard < 200) begin
            en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(en);
            if (en) n++;
            guard++;
        end
        if (delay > 0) begin
            chk({tag, " no read while stalled"}, 32'(rd_seen), 32'd0);
            chk({tag, " held in HALT"}, 32'({dif.halt_req, dif.dma_active}), 32'b10);
        end
        dif.cpu_halted = 1'b1;
        align = (put == 1'b0);
        exp_n = delay + 1 + int'(align) + 2 * XferLen;
        while (dif.halt_req === 1'b1 && n < 3000) begin
            en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (retrig && n == 40) begin
                dif.cpu_we    = 1'b1;
                dif.cpu_wdata = page ^ 8'h55;
                en = 1'b1;
            end
            step(en);
            dif.cpu_we = 1'b0;
            if (en) n++;
            if (abort && wr_seen >= 100) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals({tag, " async reset"});
                wr_snap = wr_seen;
                clk_en = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                put = 1'b0;
                repeat (4) step(1'b1);
                chk({tag, " no write after reset"}, 32'(wr_seen), 32'(wr_snap));
                chk({tag, " idle after reset"}, 32'(dif.halt_req), 32'd0);
                exp_rd.delete();
                exp_wr.delete();
                return;
            end
        end
        last_n = n;
        chk({tag, " cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " align cycles"}, 32'(align_seen), 32'(align));
        chk({tag, " inactive at end"}, 32'({dif.halt_req, dif.dma_active}), 32'd0);
        chk({tag, " reads left"}, 32'(exp_rd.size()), 32'd0);
        chk({tag, " writes left"}, 32'(exp_wr.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < XferLen; i++)
            if (oam_model[8'(start + 8'(i))] !== memval({page, 8'(i)})) bad++;
        chk({tag, " OAM contents"}, 32'(bad), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < XferLen; i++) oam_model[i] = 8'hxx;
        do_reset();
        check_reset_vals("reset");

        run_xfer(8'h02, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0, "even");
        chk("even total 513", 32'(last_n), 32'd513);

        run_xfer(8'h07, 8'h00, 1, 0, 1'b0, 1'b0, 1'b0, "odd");
        chk("odd total 514", 32'(last_n), 32'd514);

        run_xfer(8'h03, 8'hF0, -1, 0, 1'b0, 1'b0, 1'b0, "offset");
        chk("offset $0300->F0", 32'(oam_model[8'hF0]), 32'(memval(16'h0300)));
        chk("offset $0310->00", 32'(oam_model[8'h00]), 32'(memval(16'h0310)));
        chk("offset $03FF->EF", 32'(oam_model[8'hEF]), 32'(memval(16'h03FF)));

        run_xfer(8'h11, 8'h20, -1, 5, 1'b1, 1'b0, 1'b0, "stall");
        run_xfer(8'h22, 8'h00, -1, 0, 1'b1, 1'b1, 1'b0, "retrig");
        run_xfer(8'h33, 8'h00, -1, 0, 1'b0, 1'b0, 1'b1, "abort");
        run_xfer(8'h44, 8'h10, -1, 0, 1'b1, 1'b0, 1'b0, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA master for the PPU's object attribute memory. When the CPU writes a page number to $4014, the block asks the CPU to halt and takes over the CPU bus. It then copies 256 bytes from CPU page $XX00–$XXFF into OAM through the OAM write port, starting at the current OAMADDR. It sits between the CPU bus fabric and the PPU OAM, acting as the write-side initiator that drives OAM address, write-enable and data.

## Interface
Parameters:
- OAM_AW, 8, OAM address width; OAM addresses wrap modulo 2**OAM_AW.
- XFER_LEN, 256, bytes per transfer; fixed, not a runtime value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  CPU-cycle enable; all state advances only when high
- cpu_addr  in  16  CPU bus address
- cpu_we  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_halted  in  1  CPU confirms it is halted and the bus is released
- oam_start  in  OAM_AW  current OAMADDR, sampled at trigger
- halt_req  out  1  request for the CPU to halt; high from trigger until transfer done
- dma_active  out  1  high while the block owns the bus (ALIGN/READ/WRITE)
- mem_addr  out  16  bus read address; valid while mem_rd is high
- mem_rd  out  1  bus read strobe
- mem_rdata  in  8  read data, valid in the same enabled cycle as mem_rd
- oam_addr  out  OAM_AW  OAM write address
- oam_we  out  1  OAM write enable, one enabled cycle per byte
- oam_wdata  out  8  OAM write data

## Operation
- Trigger: clk_en && cpu_we && cpu_addr==16'h4014 while in IDLE. On trigger, latch page=cpu_wdata, base=oam_start and idx=0, then go to HALT. Triggers in any other state are ignored.
- Parity flag put: toggles every clk_en, resets to 0. Get cycle = put==0, put cycle = put==1.
- States, each transition taken on clk_en:
  - IDLE: halt_req=0. On trigger, go to HALT.
  - HALT: halt_req=1. Stay while cpu_halted==0. When cpu_halted==1, go to READ if the next cycle is a get cycle, otherwise go to ALIGN.
  - ALIGN: one dummy cycle with no read and no write. Go to READ.
  - READ: mem_rd=1, mem_addr={page, idx}. Latch mem_rdata into the data register. Go to WRITE.
  - WRITE: oam_we=1, oam_addr=base+idx (truncated to OAM_AW), oam_wdata=data register. If idx==XFER_LEN-1, go to IDLE; otherwise idx+1 and go to READ.
- idx is 8 bits wide. OAM address arithmetic is modulo 2**OAM_AW, so a transfer starting at a nonzero OAMADDR wraps around OAM.
- cpu_halted is not rechecked once the block leaves HALT.

## Timing
- Reset values of all outputs: halt_req=0, dma_active=0, mem_rd=0, mem_addr=0, oam_we=0, oam_addr=0, oam_wdata=0. Internal state: IDLE, put=0, idx=0.
- Outputs are registered from state, not taken from the inputs of the current cycle.
- halt_req rises in the first enabled cycle after the trigger.
- With cpu_halted already high: 1 HALT cycle + 0/1 ALIGN cycle + 512 cycles (256 READ/WRITE pairs). That is 513 or 514 enabled cycles from trigger to the return to IDLE.
- halt_req and dma_active fall in the enabled cycle after the last WRITE. A new trigger is accepted from that cycle onward.
- With clk_en low, all outputs hold and no write occurs, even in WRITE.
- Reset mid-transfer: immediately return to IDLE with the reset values above. The partial OAM contents are left as written.

## Structure
- Shared PPU package holds:
  - state typedef: IDLE, HALT, ALIGN, READ, WRITE
  - localparam OAMDMA_REG = 16'h4014
  - XFER_LEN
- Single module, no sub-modules. The counter, parity flag and FSM are all inline.

## Test plan
- Even alignment: write $02 to $4014 with cpu_halted=1 and oam_start=0, with the next cycle a get cycle. Required: reads $0200..$02FF in order, and OAM[i]==mem[$0200+i] for every i. Exactly 513 enabled cycles from trigger to halt_req=0.
- Odd alignment: same as above, but triggered one cycle later in parity. Required: one ALIGN cycle with mem_rd=0 and oam_we=0, and 514 cycles in total.
- OAMADDR offset: oam_start=$F0, page $03. Required: the byte from $0300 lands at OAM $F0, the byte from $0310 at OAM $00, and the last byte at OAM $EF.
- Handshake and stalls: hold cpu_halted=0 for 5 cycles after the trigger, and drop clk_en for random gaps. Required: stays in HALT with no reads for those 5 cycles, no oam_we while clk_en is low, and the data is still correct.
- Retrigger and reset: a second $4014 write mid-transfer is ignored, and the transfer completes with the original page. Asserting rst_n low at byte 100 drops halt_req to 0 immediately with no further oam_we; a fresh trigger after release completes normally.
